// File: rtl/rx_wr_mem_pkg.sv
// Shared types and constants for the RX payload write engine: FSM states, NoC header layout, beat math.
package rx_wr_mem_pkg;
    localparam int XY_WIDTH            = 8;
    localparam int FLOW_ID_W           = 3;
    localparam int PAYLOAD_PTR_W       = 16;
    localparam int MSG_DATA_SIZE_WIDTH = 16;
    localparam int MAC_INTERFACE_W     = 256;
    localparam int MAC_PADBYTES_W      = 5;
    localparam int NOC_DATA_WIDTH      = 512;
    localparam int MSG_TYPE_W          = 8;
    localparam int BYTES_PER_BEAT      = MAC_INTERFACE_W / 8;
    localparam int BEAT_SHIFT          = $clog2(BYTES_PER_BEAT);

    localparam logic [MSG_TYPE_W-1:0] MSG_TYPE_STORE_MEM     = 8'h20;
    localparam logic [MSG_TYPE_W-1:0] MSG_TYPE_STORE_MEM_ACK = 8'h21;

    localparam int HDR_USED = 4*XY_WIDTH + MSG_TYPE_W + MSG_DATA_SIZE_WIDTH
                            + FLOW_ID_W + PAYLOAD_PTR_W + MSG_DATA_SIZE_WIDTH;
    localparam int HDR_PAD  = NOC_DATA_WIDTH - HDR_USED;

    typedef enum logic [2:0] {IDLE, HDR, DATA, WAIT_RESP, DONE} state_e;

    typedef struct packed {
        logic [XY_WIDTH-1:0]                      dst_x;
        logic [XY_WIDTH-1:0]                      dst_y;
        logic [XY_WIDTH-1:0]                      src_x;
        logic [XY_WIDTH-1:0]                      src_y;
        logic [MSG_TYPE_W-1:0]                    msg_type;
        logic [MSG_DATA_SIZE_WIDTH-1:0]           msg_len;
        logic [FLOW_ID_W+PAYLOAD_PTR_W-1:0]       addr;
        logic [MSG_DATA_SIZE_WIDTH-1:0]           data_size;
        logic [HDR_PAD-1:0]                       rsvd;
    } noc_hdr_t;

    function automatic logic [MSG_DATA_SIZE_WIDTH-1:0] calc_beats(input logic [MSG_DATA_SIZE_WIDTH-1:0] size);
        logic [MSG_DATA_SIZE_WIDTH-1:0] q;
        q = size >> BEAT_SHIFT;
        return q + {{(MSG_DATA_SIZE_WIDTH-1){1'b0}}, |size[BEAT_SHIFT-1:0]};
    endfunction
endpackage

// File: rtl/rx_wr_mem_eng_ctrl.sv
// Control FSM and beat counters for the RX payload write engine.
module rx_wr_mem_eng_ctrl
    import rx_wr_mem_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_req_val,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] i_req_size,
    input  logic                           i_data_val,
    input  logic                           i_noc_out_rdy,
    input  logic                           i_noc_in_val,
    input  logic                           i_noc_in_is_ack,
    input  logic                           i_done_rdy,
    output state_e                         o_state,
    output logic                           o_req_rdy,
    output logic                           o_req_fire,
    output logic                           o_data_rdy,
    output logic                           o_noc_out_val,
    output logic                           o_noc_in_rdy,
    output logic                           o_done_val,
    output logic                           o_beat_xfer,
    output logic [MSG_DATA_SIZE_WIDTH-1:0] o_beat_cnt,
    output logic [MSG_DATA_SIZE_WIDTH-1:0] o_beats
);
    state_e                         r_state, w_next;
    logic [MSG_DATA_SIZE_WIDTH-1:0] r_beats, r_beat_cnt;
    logic                           r_out_en;
    logic                           w_last_beat;

    assign w_last_beat = (r_beat_cnt == r_beats - MSG_DATA_SIZE_WIDTH'(1));
    assign o_req_fire  = o_req_rdy & i_req_val;
    assign o_beat_xfer = (r_state == DATA) & i_data_val & i_noc_out_rdy;
    assign o_state     = r_state;
    assign o_beat_cnt  = r_beat_cnt;
    assign o_beats     = r_beats;

    always_comb begin
        w_next        = r_state;
        o_req_rdy     = 1'b0;
        o_data_rdy    = 1'b0;
        o_noc_out_val = 1'b0;
        o_noc_in_rdy  = 1'b0;
        o_done_val    = 1'b0;
        case (r_state)
            IDLE: begin
                // r_out_en keeps req_rdy low while reset is held and for one cycle after
                o_req_rdy = r_out_en;
                if (i_req_val && r_out_en)
                    w_next = (i_req_size == '0) ? DONE : HDR;
            end
            HDR: begin
                o_noc_out_val = 1'b1;
                if (i_noc_out_rdy) w_next = DATA;
            end
            DATA: begin
                o_noc_out_val = i_data_val;
                o_data_rdy    = i_noc_out_rdy;
                if (o_beat_xfer && w_last_beat) w_next = WAIT_RESP;
            end
            WAIT_RESP: begin
                o_noc_in_rdy = 1'b1;
                if (i_noc_in_val && i_noc_in_is_ack) w_next = DONE;
            end
            DONE: begin
                o_done_val = 1'b1;
                if (i_done_rdy) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beats    <= '0;
            r_beat_cnt <= '0;
            r_out_en   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_out_en <= 1'b1;
            if (o_req_fire) begin
                r_beats    <= calc_beats(i_req_size);
                r_beat_cnt <= '0;
            end else if (o_beat_xfer) begin
                r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + MSG_DATA_SIZE_WIDTH'(1);
            end
        end
    end
endmodule

// File: rtl/rx_wr_mem_eng.sv
// RX payload write engine: one NoC0 store message per request, done after store ack.
// Optional framing/range checking is enabled by defining RX_WR_MEM_ERR_CHK_EN.
module rx_wr_mem_eng
    import rx_wr_mem_pkg::*;
#(
    parameter logic [XY_WIDTH-1:0] SRC_X      = 0,
    parameter logic [XY_WIDTH-1:0] SRC_Y      = 0,
    parameter logic [XY_WIDTH-1:0] DST_DRAM_X = 1,
    parameter logic [XY_WIDTH-1:0] DST_DRAM_Y = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           src_wr_mem_rx_req_val,
    input  logic [FLOW_ID_W-1:0]           src_wr_mem_rx_req_flowid,
    input  logic [PAYLOAD_PTR_W-1:0]       src_wr_mem_rx_req_offset,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] src_wr_mem_rx_req_size,
    output logic                           wr_mem_src_rx_req_rdy,
    input  logic                           src_wr_mem_rx_data_val,
    input  logic [MAC_INTERFACE_W-1:0]     src_wr_mem_rx_data,
    input  logic                           src_wr_mem_rx_data_last,
    input  logic [MAC_PADBYTES_W-1:0]      src_wr_mem_rx_data_padbytes,
    output logic                           wr_mem_src_rx_data_rdy,
    output logic [NOC_DATA_WIDTH-1:0]      wr_mem_noc0_data,
    output logic                           wr_mem_noc0_val,
    input  logic                           noc0_wr_mem_rdy,
    input  logic [NOC_DATA_WIDTH-1:0]      noc0_wr_mem_data,
    input  logic                           noc0_wr_mem_val,
    output logic                           wr_mem_noc0_rdy,
    output logic                           wr_mem_dst_rx_done_val,
    output logic [FLOW_ID_W-1:0]           wr_mem_dst_rx_done_flowid,
    input  logic                           dst_wr_mem_rx_done_rdy,
    output logic                           wr_mem_err
);
    state_e                         w_state;
    logic                           w_req_fire, w_beat_xfer, w_is_ack;
    logic [MSG_DATA_SIZE_WIDTH-1:0] w_beat_cnt, w_beats;
    logic [FLOW_ID_W-1:0]           r_flowid;
    logic [PAYLOAD_PTR_W-1:0]       r_offset;
    logic [MSG_DATA_SIZE_WIDTH-1:0] r_size;
    noc_hdr_t                       w_hdr, w_in_hdr;
    logic                           w_unused;

    assign w_in_hdr = noc_hdr_t'(noc0_wr_mem_data);
    assign w_is_ack = (w_in_hdr.msg_type == MSG_TYPE_STORE_MEM_ACK);
    assign w_unused = ^{noc0_wr_mem_data, src_wr_mem_rx_data_last, src_wr_mem_rx_data_padbytes, w_beat_cnt};

    rx_wr_mem_eng_ctrl u_ctrl (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_req_val       (src_wr_mem_rx_req_val),
        .i_req_size      (src_wr_mem_rx_req_size),
        .i_data_val      (src_wr_mem_rx_data_val),
        .i_noc_out_rdy   (noc0_wr_mem_rdy),
        .i_noc_in_val    (noc0_wr_mem_val),
        .i_noc_in_is_ack (w_is_ack),
        .i_done_rdy      (dst_wr_mem_rx_done_rdy),
        .o_state         (w_state),
        .o_req_rdy       (wr_mem_src_rx_req_rdy),
        .o_req_fire      (w_req_fire),
        .o_data_rdy      (wr_mem_src_rx_data_rdy),
        .o_noc_out_val   (wr_mem_noc0_val),
        .o_noc_in_rdy    (wr_mem_noc0_rdy),
        .o_done_val      (wr_mem_dst_rx_done_val),
        .o_beat_xfer     (w_beat_xfer),
        .o_beat_cnt      (w_beat_cnt),
        .o_beats         (w_beats)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flowid <= '0;
            r_offset <= '0;
            r_size   <= '0;
        end else if (w_req_fire) begin
            r_flowid <= src_wr_mem_rx_req_flowid;
            r_offset <= src_wr_mem_rx_req_offset;
            r_size   <= src_wr_mem_rx_req_size;
        end
    end

    assign wr_mem_dst_rx_done_flowid = r_flowid;

    always_comb begin
        w_hdr           = '0;
        w_hdr.dst_x     = DST_DRAM_X;
        w_hdr.dst_y     = DST_DRAM_Y;
        w_hdr.src_x     = SRC_X;
        w_hdr.src_y     = SRC_Y;
        w_hdr.msg_type  = MSG_TYPE_STORE_MEM;
        w_hdr.msg_len   = w_beats;
        w_hdr.addr      = {r_flowid, r_offset};
        w_hdr.data_size = r_size;
    end

    always_comb begin
        wr_mem_noc0_data = '0;
        if (w_state == HDR)       wr_mem_noc0_data = w_hdr;
        else if (w_state == DATA) wr_mem_noc0_data = NOC_DATA_WIDTH'(src_wr_mem_rx_data);
    end

`ifdef RX_WR_MEM_ERR_CHK_EN
    logic                      r_err, w_last_beat, w_ovf, w_frame_err;
    logic [MAC_PADBYTES_W-1:0] w_pad_exp;

    // beats*BYTES - size reduces to (-size) mod BYTES_PER_BEAT
    assign w_pad_exp   = MAC_PADBYTES_W'(0) - r_size[MAC_PADBYTES_W-1:0];
    assign w_last_beat = (w_beat_cnt == w_beats - MSG_DATA_SIZE_WIDTH'(1));
    assign w_ovf       = ({1'b0, src_wr_mem_rx_req_offset} + {1'b0, src_wr_mem_rx_req_size})
                         > {1'b1, {PAYLOAD_PTR_W{1'b0}}};
    assign w_frame_err = (src_wr_mem_rx_data_last != w_last_beat)
                         || (w_last_beat && (src_wr_mem_rx_data_padbytes != w_pad_exp));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 1'b0;
        else if ((w_req_fire && w_ovf) || (w_beat_xfer && w_frame_err))
            r_err <= 1'b1;
    end
    assign wr_mem_err = r_err;
`else
    assign wr_mem_err = 1'b0;
`endif
endmodule

// File: tb/tb_rx_wr_mem_eng.sv
// Directed self-checking bench for rx_wr_mem_eng (default and RX_WR_MEM_ERR_CHK_EN builds).
module tb_rx_wr_mem_eng;
    logic         clk;
    logic         rst_n;
    logic         req_val;
    logic [2:0]   req_flowid;
    logic [15:0]  req_offset;
    logic [15:0]  req_size;
    logic         req_rdy;
    logic         data_val;
    logic [255:0] data;
    logic         data_last;
    logic [4:0]   data_pad;
    logic         data_rdy;
    logic [511:0] noc_out;
    logic         noc_out_val;
    logic         noc_out_rdy;
    logic [511:0] noc_in;
    logic         noc_in_val;
    logic         noc_in_rdy;
    logic         done_val;
    logic [2:0]   done_flowid;
    logic         done_rdy;
    logic         err;

    int n_vec = 0;
    int n_err = 0;

`ifdef RX_WR_MEM_ERR_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic [255:0] D0, D1, D2, D3;
    logic [511:0] ACK, NONACK, HDR1, HDR3, HDR6;

    rx_wr_mem_eng dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .src_wr_mem_rx_req_val       (req_val),
        .src_wr_mem_rx_req_flowid    (req_flowid),
        .src_wr_mem_rx_req_offset    (req_offset),
        .src_wr_mem_rx_req_size      (req_size),
        .wr_mem_src_rx_req_rdy       (req_rdy),
        .src_wr_mem_rx_data_val      (data_val),
        .src_wr_mem_rx_data          (data),
        .src_wr_mem_rx_data_last     (data_last),
        .src_wr_mem_rx_data_padbytes (data_pad),
        .wr_mem_src_rx_data_rdy      (data_rdy),
        .wr_mem_noc0_data            (noc_out),
        .wr_mem_noc0_val             (noc_out_val),
        .noc0_wr_mem_rdy             (noc_out_rdy),
        .noc0_wr_mem_data            (noc_in),
        .noc0_wr_mem_val             (noc_in_val),
        .wr_mem_noc0_rdy             (noc_in_rdy),
        .wr_mem_dst_rx_done_val      (done_val),
        .wr_mem_dst_rx_done_flowid   (done_flowid),
        .dst_wr_mem_rx_done_rdy      (done_rdy),
        .wr_mem_err                  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // header layout: dst_x,dst_y,src_x,src_y,type,len,flowid,offset,size,pad
        D0     = {8{32'hA0A1A2A3}};
        D1     = {8{32'hB4B5B6B7}};
        D2     = {8{32'hC8C9CACB}};
        D3     = {8{32'hDCDDDEDF}};
        ACK    = {32'd0, 8'h21, 472'd0};
        NONACK = {32'd0, 8'h20, 472'd5};
        HDR1   = {8'd1, 8'd0, 8'd0, 8'd0, 8'h20, 16'd2, 3'd3, 16'h0010, 16'd64, 421'd0};
        HDR3   = {8'd1, 8'd0, 8'd0, 8'd0, 8'h20, 16'd2, 3'd1, 16'h0100, 16'd33, 421'd0};
        HDR6   = {8'd1, 8'd0, 8'd0, 8'd0, 8'h20, 16'd1, 3'd6, 16'h0040, 16'd32, 421'd0};

        rst_n = 1'b0; req_val = 1'b0; req_flowid = '0; req_offset = '0; req_size = '0;
        data_val = 1'b0; data = '0; data_last = 1'b0; data_pad = '0;
        noc_out_rdy = 1'b0; noc_in = '0; noc_in_val = 1'b0; done_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_rdy", 512'(req_rdy), 512'd0);
        chk("rst_data_rdy", 512'(data_rdy), 512'd0);
        chk("rst_noc_val", 512'(noc_out_val), 512'd0);
        chk("rst_noc_in_rdy", 512'(noc_in_rdy), 512'd0);
        chk("rst_done_val", 512'(done_val), 512'd0);
        chk("rst_done_flowid", 512'(done_flowid), 512'd0);
        chk("rst_err", 512'(err), 512'd0);
        rst_n = 1'b1;
        cyc();
        chk("idle_req_rdy", 512'(req_rdy), 512'd1);

        // size 64, back-to-back data
        req_val = 1'b1; req_flowid = 3'd3; req_offset = 16'h0010; req_size = 16'd64; noc_out_rdy = 1'b1;
        #1;
        chk("t1_noc_quiet", 512'(noc_out_val), 512'd0);
        cyc(); req_val = 1'b0; #1;
        chk("t1_hdr_val", 512'(noc_out_val), 512'd1);
        chk("t1_hdr", noc_out, HDR1);
        chk("t1_hdr_data_rdy", 512'(data_rdy), 512'd0);
        cyc(); data_val = 1'b1; data = D0; data_last = 1'b0; #1;
        chk("t1_flit0", noc_out, {256'd0, D0});
        chk("t1_data_rdy", 512'(data_rdy), 512'd1);
        cyc(); data = D1; data_last = 1'b1; #1;
        chk("t1_flit1", noc_out, {256'd0, D1});
        chk("t1_flit1_val", 512'(noc_out_val), 512'd1);
        cyc(); data_val = 1'b0; data_last = 1'b0; #1;
        chk("t1_wait_noc_val", 512'(noc_out_val), 512'd0);
        chk("t1_wait_rdy", 512'(noc_in_rdy), 512'd1);
        chk("t1_wait_done", 512'(done_val), 512'd0);
        noc_in_val = 1'b1; noc_in = ACK;
        cyc(); noc_in_val = 1'b0; #1;
        chk("t1_done_val", 512'(done_val), 512'd1);
        chk("t1_done_flowid", 512'(done_flowid), 512'd3);
        chk("t1_done_noc_in_rdy", 512'(noc_in_rdy), 512'd0);
        done_rdy = 1'b1;
        cyc(); done_rdy = 1'b0; #1;
        chk("t1_idle_done", 512'(done_val), 512'd0);
        chk("t1_idle_req_rdy", 512'(req_rdy), 512'd1);

        // size 0: straight to done
        req_val = 1'b1; req_flowid = 3'd5; req_offset = 16'h0; req_size = 16'd0;
        cyc(); req_val = 1'b0; #1;
        chk("t2_done_val", 512'(done_val), 512'd1);
        chk("t2_done_flowid", 512'(done_flowid), 512'd5);
        chk("t2_noc_val", 512'(noc_out_val), 512'd0);
        done_rdy = 1'b1;
        cyc(); done_rdy = 1'b0; #1;
        chk("t2_req_rdy", 512'(req_rdy), 512'd1);
        chk("t2_noc_val_after", 512'(noc_out_val), 512'd0);

        // size 33 with stalls
        noc_out_rdy = 1'b0;
        req_val = 1'b1; req_flowid = 3'd1; req_offset = 16'h0100; req_size = 16'd33;
        cyc(); req_val = 1'b0; #1;
        chk("t3_hdr", noc_out, HDR3);
        cyc();
        chk("t3_hdr_stall", noc_out, HDR3);
        chk("t3_hdr_stall_val", 512'(noc_out_val), 512'd1);
        noc_out_rdy = 1'b1;
        cyc(); noc_out_rdy = 1'b0; data_val = 1'b1; data = D2; data_last = 1'b0; data_pad = 5'd0; #1;
        chk("t3_data_rdy_stall", 512'(data_rdy), 512'd0);
        chk("t3_flit0", noc_out, {256'd0, D2});
        cyc();
        chk("t3_flit0_stall", noc_out, {256'd0, D2});
        chk("t3_flit0_stall_val", 512'(noc_out_val), 512'd1);
        noc_out_rdy = 1'b1; #1;
        chk("t3_data_rdy", 512'(data_rdy), 512'd1);
        cyc(); noc_out_rdy = 1'b0; data = D3; data_last = 1'b1; data_pad = 5'd31; #1;
        chk("t3_flit1", noc_out, {256'd0, D3});
        cyc(); noc_out_rdy = 1'b1;
        cyc(); data_val = 1'b0; data_last = 1'b0; data_pad = 5'd0; #1;
        chk("t3_wait_rdy", 512'(noc_in_rdy), 512'd1);
        chk("t3_err", 512'(err), 512'd0);

        // non-ack flit in WAIT_RESP is ignored
        noc_in_val = 1'b1; noc_in = NONACK;
        cyc();
        chk("t4_ignored_done", 512'(done_val), 512'd0);
        chk("t4_still_wait", 512'(noc_in_rdy), 512'd1);
        noc_in = ACK;
        cyc(); noc_in_val = 1'b0; #1;
        chk("t4_done_val", 512'(done_val), 512'd1);
        chk("t4_done_flowid", 512'(done_flowid), 512'd1);
        done_rdy = 1'b1;
        cyc(); done_rdy = 1'b0;

        // size 64 with early last
        noc_out_rdy = 1'b1;
        req_val = 1'b1; req_flowid = 3'd2; req_offset = 16'h0; req_size = 16'd64;
        cyc(); req_val = 1'b0;
        cyc(); data_val = 1'b1; data = D0; data_last = 1'b1; #1;
        chk("t5_flit0_val", 512'(noc_out_val), 512'd1);
        cyc(); data = D1; data_last = 1'b1; #1;
        chk("t5_flit1", noc_out, {256'd0, D1});
        chk("t5_flit1_val", 512'(noc_out_val), 512'd1);
        cyc(); data_val = 1'b0; data_last = 1'b0; #1;
        chk("t5_wait_rdy", 512'(noc_in_rdy), 512'd1);
        chk("t5_err", 512'(err), 512'(ERR_EXP));
        noc_in_val = 1'b1; noc_in = ACK;
        cyc(); noc_in_val = 1'b0; #1;
        chk("t5_done_flowid", 512'(done_flowid), 512'd2);
        done_rdy = 1'b1;
        cyc(); done_rdy = 1'b0;

        // reset mid-DATA of 4-beat write
        req_val = 1'b1; req_flowid = 3'd4; req_offset = 16'h0200; req_size = 16'd128;
        cyc(); req_val = 1'b0;
        cyc(); data_val = 1'b1; data = D0; data_last = 1'b0;
        cyc(); data = D1; #1;
        chk("t6_in_data", 512'(noc_out_val), 512'd1);
        rst_n = 1'b0; #1;
        chk("t6_rst_noc_val", 512'(noc_out_val), 512'd0);
        chk("t6_rst_noc_data", noc_out, 512'd0);
        chk("t6_rst_data_rdy", 512'(data_rdy), 512'd0);
        chk("t6_rst_req_rdy", 512'(req_rdy), 512'd0);
        chk("t6_rst_noc_in_rdy", 512'(noc_in_rdy), 512'd0);
        chk("t6_rst_done_val", 512'(done_val), 512'd0);
        chk("t6_rst_flowid", 512'(done_flowid), 512'd0);
        chk("t6_rst_err", 512'(err), 512'd0);
        data_val = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc();
        chk("t6_req_rdy", 512'(req_rdy), 512'd1);
        req_val = 1'b1; req_flowid = 3'd6; req_offset = 16'h0040; req_size = 16'd32;
        cyc(); req_val = 1'b0; #1;
        chk("t6_hdr", noc_out, HDR6);
        cyc(); data_val = 1'b1; data = D2; data_last = 1'b1; data_pad = 5'd0; #1;
        chk("t6_flit0", noc_out, {256'd0, D2});
        cyc(); data_val = 1'b0; data_last = 1'b0; #1;
        chk("t6_wait_rdy", 512'(noc_in_rdy), 512'd1);
        noc_in_val = 1'b1; noc_in = ACK;
        cyc(); noc_in_val = 1'b0; #1;
        chk("t6_done_val", 512'(done_val), 512'd1);
        chk("t6_done_flowid", 512'(done_flowid), 512'd6);
        chk("t6_err", 512'(err), 512'd0);
        done_rdy = 1'b1;
        cyc(); done_rdy = 1'b0; #1;
        chk("t6_final_req_rdy", 512'(req_rdy), 512'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
